decode: RTL

DECODE -- requirements
Module: decode

---
 rtl/cpu_pkg.sv | 70 +++++++
 rtl/regfile.sv | 27 ++
 rtl/decode.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU operation and
// immediate-format enumerations, and the immediate generator.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  function automatic logic [31:0] gen_imm(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = 32'd0;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'd0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 integer register file, two combinational read ports and one write
// port at posedge. x0 always reads zero; contents are not reset.
module regfile
  import cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic [4:0]  i_raddr1,
  output logic [31:0] o_rdata1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_mem [0:31];

  always_ff @(posedge i_clk) begin
    if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_mem[i_raddr2];

endmodule

// File: rtl/decode.sv
// RV32I decode stage: decodes the if_id instruction, reads the register file
// and registers everything into id_ex, raising a one-cycle load-use stall.
module decode
  import cpu_pkg::*;
#(
  parameter bit RESET_VALID = 1'b0,
  parameter bit WB_BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_flush,
  input  logic [31:0] if_id__pc,
  input  logic [31:0] if_id__ins,
  input  logic        if_id__predict_taken,
  input  logic [31:0] if_id__predict_target,
  input  logic        if_id__data_hazard,
  input  logic        if_id__instret,
  input  logic        wb_id__we,
  input  logic [4:0]  wb_id__rd,
  input  logic [31:0] wb_id__data,
  output logic        data_hazard,
  output logic        id_ex__valid,
  output logic [31:0] id_ex__pc,
  output logic [31:0] id_ex__rs1_data,
  output logic [31:0] id_ex__rs2_data,
  output logic [31:0] id_ex__imm,
  output logic [4:0]  id_ex__rs1,
  output logic [4:0]  id_ex__rs2,
  output logic [4:0]  id_ex__rd,
  output logic [3:0]  id_ex__alu_op,
  output logic        id_ex__mem_read,
  output logic        id_ex__mem_write,
  output logic        id_ex__reg_write,
  output logic        id_ex__branch,
  output logic        id_ex__jump,
  output logic        id_ex__illegal,
  output logic        id_ex__instret,
  output logic        id_ex__predict_taken,
  output logic [31:0] id_ex__predict_target
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  imm_fmt_e    w_fmt;
  alu_op_e     w_alu_op;
  logic        w_reg_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_jump;
  logic        w_illegal;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic [31:0] w_imm;
  logic [31:0] w_rf_rdata1;
  logic [31:0] w_rf_rdata2;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;
  logic        w_dv;

  assign w_opcode = if_id__ins[6:0];
  assign w_funct3 = if_id__ins[14:12];
  assign w_rs1    = if_id__ins[19:15];
  assign w_rs2    = if_id__ins[24:20];
  assign w_rd     = if_id__ins[11:7];

  // Every listed opcode ends in 2'b11, so ins[1:0]!=2'b11 lands in default.
  always_comb begin
    w_fmt       = IMM_NONE;
    w_alu_op    = ALU_ADD;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_jump      = 1'b0;
    w_illegal   = 1'b0;
    w_uses_rs1  = 1'b0;
    w_uses_rs2  = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_fmt       = IMM_U;
        w_alu_op    = ALU_PASSB;
        w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_fmt       = IMM_U;
        w_reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_fmt       = IMM_J;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
      end
      OPC_JALR: begin
        w_fmt       = IMM_I;
        w_reg_write = 1'b1;
        w_jump      = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      OPC_BRANCH: begin
        w_fmt      = IMM_B;
        w_branch   = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        case (w_funct3[2:1])
          2'b00:   w_alu_op = ALU_SUB;
          2'b10:   w_alu_op = ALU_SLT;
          default: w_alu_op = ALU_SLTU;
        endcase
      end
      OPC_LOAD: begin
        w_fmt       = IMM_I;
        w_reg_write = 1'b1;
        w_mem_read  = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      OPC_STORE: begin
        w_fmt       = IMM_S;
        w_mem_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OPC_OP_IMM: begin
        w_fmt       = IMM_I;
        w_alu_op    = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && if_id__ins[30]);
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
      end
      OPC_OP: begin
        w_alu_op    = alu_from_funct3(w_funct3, if_id__ins[30]);
        w_reg_write = 1'b1;
        w_uses_rs1  = 1'b1;
        w_uses_rs2  = 1'b1;
      end
      OPC_FENCE: begin
        w_fmt = IMM_I;
      end
      OPC_SYSTEM: begin
        // CSR forms write rd; register-source CSR forms also read rs1.
        w_fmt       = IMM_I;
        w_reg_write = (w_funct3 != 3'b000);
        w_uses_rs1  = (w_funct3 != 3'b000) && !w_funct3[2];
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_imm = gen_imm(if_id__ins, w_fmt);

  regfile u_regfile (
    .i_clk    (clk),
    .i_raddr1 (w_rs1),
    .o_rdata1 (w_rf_rdata1),
    .i_raddr2 (w_rs2),
    .o_rdata2 (w_rf_rdata2),
    .i_we     (wb_id__we),
    .i_waddr  (wb_id__rd),
    .i_wdata  (wb_id__data)
  );

  assign w_rs1_data = (WB_BYPASS && wb_id__we && (wb_id__rd == w_rs1) && (w_rs1 != 5'd0))
                      ? wb_id__data : w_rf_rdata1;
  assign w_rs2_data = (WB_BYPASS && wb_id__we && (wb_id__rd == w_rs2) && (w_rs2 != 5'd0))
                      ? wb_id__data : w_rf_rdata2;

  // A flushed slot never stalls; the bubble it produces clears mem_read,
  // which bounds every load-use stall to a single cycle.
  assign data_hazard = !pipe_flush && id_ex__valid && id_ex__mem_read &&
                       (id_ex__rd != 5'd0) &&
                       ((w_uses_rs1 && (w_rs1 == id_ex__rd)) ||
                        (w_uses_rs2 && (w_rs2 == id_ex__rd)));

  assign w_dv = !pipe_flush && !if_id__data_hazard && !data_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex__valid          <= RESET_VALID;
      id_ex__pc             <= 32'd0;
      id_ex__rs1_data       <= 32'd0;
      id_ex__rs2_data       <= 32'd0;
      id_ex__imm            <= 32'd0;
      id_ex__rs1            <= 5'd0;
      id_ex__rs2            <= 5'd0;
      id_ex__rd             <= 5'd0;
      id_ex__alu_op         <= 4'd0;
      id_ex__mem_read       <= 1'b0;
      id_ex__mem_write      <= 1'b0;
      id_ex__reg_write      <= 1'b0;
      id_ex__branch         <= 1'b0;
      id_ex__jump           <= 1'b0;
      id_ex__illegal        <= 1'b0;
      id_ex__instret        <= 1'b0;
      id_ex__predict_taken  <= 1'b0;
      id_ex__predict_target <= 32'd0;
    end else begin
      id_ex__valid          <= w_dv;
      id_ex__pc             <= if_id__pc;
      id_ex__rs1_data       <= w_rs1_data;
      id_ex__rs2_data       <= w_rs2_data;
      id_ex__imm            <= w_imm;
      id_ex__rs1            <= w_rs1;
      id_ex__rs2            <= w_rs2;
      id_ex__rd             <= w_rd;
      id_ex__alu_op         <= w_alu_op;
      id_ex__mem_read       <= w_mem_read  && w_dv;
      id_ex__mem_write      <= w_mem_write && w_dv;
      id_ex__reg_write      <= w_reg_write && w_dv;
      id_ex__branch         <= w_branch    && w_dv;
      id_ex__jump           <= w_jump      && w_dv;
      id_ex__illegal        <= w_illegal   && w_dv;
      id_ex__instret        <= if_id__instret && w_dv;
      id_ex__predict_taken  <= if_id__predict_taken;
      id_ex__predict_target <= if_id__predict_target;
    end
  end

endmodule
